// File: rtl/result_sig_collector.sv
// result_sig_collector: FIFO buffer plus rotate-XOR frame signature
// for the datapath result stream.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   clear          synchronous soft clear, same effect as reset
//   in_valid/in_data/in_ready     upstream handshake
//   out_valid/out_data/out_ready  downstream handshake (FIFO head)
//   level          FIFO occupancy
//   count          saturating count of accepted words
//   frame_sig      signature of last completed frame
//   frame_done     one-cycle pulse after frame_sig updates
module result_sig_collector #(
  parameter int DATA_W    = 10,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           count,
  output logic [DATA_W-1:0]          frame_sig,
  output logic                       frame_done
);

  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;
  localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);
  localparam logic [LW-1:0]   FULL    = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [LW-1:0]     level_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] sig;
  logic [DATA_W-1:0] sig_next;
  logic [FC_W-1:0]   frame_cnt;
  logic [DATA_W-1:0] frame_sig_q;
  logic              frame_done_q;
  logic              accept;
  logic              pop;
  logic              wipe;

  assign in_ready   = (level_q != FULL);
  assign out_valid  = (level_q != '0);
  assign out_data   = mem[rd_ptr];
  assign level      = level_q;
  assign count      = count_q;
  assign frame_sig  = frame_sig_q;
  assign frame_done = frame_done_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign wipe   = !rst_n || clear;

  assign sig_next = {sig[DATA_W-2:0], sig[DATA_W-1]} ^ in_data;

  // Storage carries no reset; out_data is ignored while out_valid=0.
  always_ff @(posedge clk) begin
    if (!wipe && accept) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      unique case ({accept, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      count_q      <= '0;
      sig          <= '0;
      frame_cnt    <= '0;
      frame_sig_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (accept) begin
        if (count_q != '1) count_q <= count_q + 1'b1;
        if (frame_cnt == FC_LAST) begin
          frame_sig_q  <= sig_next;
          sig          <= '0;
          frame_cnt    <= '0;
          frame_done_q <= 1'b1;
        end else begin
          sig       <= sig_next;
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_sig_collector.sv
// tb_result_sig_collector: randomized and directed checks of
// result_sig_collector against a queue-based reference model.
module tb_result_sig_collector;

  localparam int DW = 10;
  localparam int DP = 4;
  localparam int FL = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [2:0]    level;
  logic [CW-1:0] count;
  logic [DW-1:0] frame_sig;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] mframe[$];
  int            m_count;
  logic [DW-1:0] m_sig;
  logic          m_done;

  always #5 clk = ~clk;

  result_sig_collector #(
    .DATA_W(DW), .DEPTH(DP), .FRAME_LEN(FL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .level(level), .count(count),
    .frame_sig(frame_sig), .frame_done(frame_done)
  );

  // signature of a whole frame: fold of rotate-left-then-xor
  function automatic logic [DW-1:0] fold(input logic [DW-1:0] w[$]);
    int s = 0;
    foreach (w[i]) begin
      s = ((s << 1) | (s >> (DW - 1))) & ((1 << DW) - 1);
      s = s ^ int'(w[i]);
    end
    return DW'(s);
  endfunction

  task automatic model_wipe();
    mq.delete();
    mframe.delete();
    m_count = 0;
    m_sig   = '0;
    m_done  = 1'b0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model.
  task automatic tick(input logic v, input logic [DW-1:0] d,
                      input logic r, input logic c, input logic rn);
    logic acc, pp;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clear     = c;
    rst_n     = rn;
    acc = v && (mq.size() != DP);
    pp  = r && (mq.size() != 0);
    @(posedge clk);
    if (!rn || c) begin
      model_wipe();
    end else begin
      m_done = 1'b0;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(d);
        mframe.push_back(d);
        if (m_count < (1 << CW) - 1) m_count++;
        if (mframe.size() == FL) begin
          m_sig  = fold(mframe);
          m_done = 1'b1;
          mframe.delete();
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(0, '0, 0, 0, 0);
    tick(0, '0, 0, 0, 0);
    tick(0, '0, 0, 0, 1);
    checks++;
    if (level !== 3'd0) begin
      errors++; $display("FAIL reset_level got %0d want 0", level);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (count !== '0) begin
      errors++; $display("FAIL reset_count got %0d want 0", count);
    end
    checks++;
    if (frame_sig !== '0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame got sig=%h done=%b want 0/0",
               frame_sig, frame_done);
    end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] w[4];
    w = '{10'h011, 10'h022, 10'h033, 10'h044};
    tick(0, '0, 0, 1, 1);
    for (int i = 0; i < 4; i++) tick(1, w[i], 0, 0, 1);
    checks++;
    if (level !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state got level=%0d rdy=%b want 4/0",
               level, in_ready);
    end
    tick(1, 10'h055, 0, 0, 1);
    checks++;
    if (level !== 3'd4 || count !== 4'd4) begin
      errors++;
      $display("FAIL fifth_word got level=%0d cnt=%0d want 4/4",
               level, count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== w[i]) begin
        errors++;
        $display("FAIL drain_%0d got v=%b d=%h want 1/%h",
                 i, out_valid, out_data, w[i]);
      end
      tick(0, '0, 1, 0, 1);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_signature();
    logic [DW-1:0] w[4];
    w = '{10'h3FF, 10'h001, 10'h200, 10'h155};
    tick(0, '0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1, w[i], 1, 0, 1);
      if (i < 3) begin
        checks++;
        if (frame_done !== 1'b0) begin
          errors++; $display("FAIL early_done_%0d got 1 want 0", i);
        end
      end
    end
    checks++;
    if (frame_done !== 1'b1 || frame_sig !== 10'h2AF || count !== 4'd4) begin
      errors++;
      $display("FAIL sig_frame got done=%b sig=%h cnt=%0d want 1/2af/4",
               frame_done, frame_sig, count);
    end
    tick(0, '0, 1, 0, 1);
    checks++;
    if (frame_done !== 1'b0 || frame_sig !== 10'h2AF) begin
      errors++;
      $display("FAIL sig_pulse got done=%b sig=%h want 0/2af",
               frame_done, frame_sig);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    tick(0, '0, 0, 1, 1);
    tick(1, DW'($urandom_range(0, 1023)), 0, 0, 1);
    tick(1, DW'($urandom_range(0, 1023)), 0, 0, 1);
    c0 = m_count;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_data !== mq[0]) begin
        errors++;
        $display("FAIL b2b_order_%0d got %h want %h", i, out_data, mq[0]);
      end
      tick(1, DW'($urandom_range(0, 1023)), 1, 0, 1);
      checks++;
      if (level !== 3'd2) begin
        errors++; $display("FAIL b2b_level_%0d got %0d want 2", i, level);
      end
    end
    checks++;
    if (int'(count) != c0 + 5 || m_count != c0 + 5) begin
      errors++;
      $display("FAIL b2b_count got %0d want %0d", count, c0 + 5);
    end
  endtask

  task automatic test_clear_mid();
    logic [DW-1:0] w[4];
    w = '{10'h3FF, 10'h001, 10'h200, 10'h155};
    tick(0, '0, 0, 1, 1);
    for (int i = 0; i < 3; i++) tick(1, 10'h0AA, 0, 0, 1);
    tick(1, 10'h0AA, 0, 1, 1);
    checks++;
    if (frame_done !== 1'b0 || count !== '0 || level !== 3'd0) begin
      errors++;
      $display("FAIL clear_mid got done=%b cnt=%0d lvl=%0d want 0/0/0",
               frame_done, count, level);
    end
    tick(0, '0, 0, 0, 1);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL clear_late_done got 1 want 0");
    end
    for (int i = 0; i < 4; i++) tick(1, w[i], 1, 0, 1);
    checks++;
    if (frame_done !== 1'b1 || frame_sig !== 10'h2AF) begin
      errors++;
      $display("FAIL clear_resig got done=%b sig=%h want 1/2af",
               frame_done, frame_sig);
    end
  endtask

  task automatic test_saturation();
    tick(0, '0, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      tick(1, DW'($urandom_range(0, 1023)), 1, 0, 1);
      checks++;
      if (out_data !== mq[0] || frame_sig !== m_sig) begin
        errors++;
        $display("FAIL sat_%0d got d=%h sig=%h want %h/%h",
                 i, out_data, frame_sig, mq[0], m_sig);
      end
    end
    checks++;
    if (count !== 4'hF) begin
      errors++; $display("FAIL sat_count got %h want f", count);
    end
  endtask

  task automatic test_random();
    tick(0, '0, 0, 1, 1);
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, DW'($urandom_range(0, 1023)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0, 1);
      checks++;
      if (int'(level) != mq.size() || int'(count) != m_count ||
          frame_done !== m_done || frame_sig !== m_sig ||
          in_ready !== (mq.size() != DP) ||
          out_valid !== (mq.size() != 0) ||
          (mq.size() != 0 && out_data !== mq[0])) begin
        errors++;
        $display("FAIL rand_%0d got l=%0d c=%0d fd=%b fs=%h od=%h want l=%0d c=%0d fd=%b fs=%h od=%h",
                 i, level, count, frame_done, frame_sig, out_data,
                 mq.size(), m_count, m_done, m_sig,
                 (mq.size() != 0) ? mq[0] : '0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    model_wipe();
    test_reset();
    test_fill_drain();
    test_signature();
    test_back_to_back();
    test_clear_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_sig_collector.md
Name: result_sig_collector

Overview:
- Downstream consumer of the 10-bit combinational result word (output_data) produced by the upstream datapath stage.
- Buffers result words in a small FIFO with valid/ready handshakes on both sides.
- Compresses every accepted word into a rotate-XOR signature. Each signature covers a fixed-length frame, and the block reports it at the end of that frame.
- Gives the checker/scoreboard stage a compact, cycle-independent view of the datapath output stream.

Parameters:
- DATA_W, 10, width of result word (matches upstream output_data).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- FRAME_LEN, 8, accepted words per signature frame; >= 1.
- CNT_W, 16, width of total accepted-word counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- clear  in  1  synchronous soft clear (same effect as reset on all state).
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_W  upstream result word (output_data).
- in_ready  out  1  block can accept a word.
- out_valid  out  1  FIFO head valid.
- out_data  out  DATA_W  FIFO head word.
- out_ready  in  1  downstream consumes head.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- count  out  CNT_W  total accepted words, saturating.
- frame_sig  out  DATA_W  signature of last completed frame.
- frame_done  out  1  one-cycle pulse, frame_sig just updated.

Behaviour:
- Reset (rst_n=0 at clk edge) or clear=1:
  - level, read/write pointers, count, running sig, frame counter, frame_sig and frame_done all go to 0.
  - out_valid=0; out_data is don't-care while out_valid=0.
  - Reset has priority over clear. clear has priority over any accept or pop in the same cycle: the accepted word is discarded, not counted and not signed.
- Handshake:
  - accept = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (level != DEPTH), registered-state only. No combinational path from out_ready, so a full FIFO with a simultaneous pop still deasserts in_ready.
  - out_valid = (level != 0).
- FIFO:
  - Register-array storage; out_data = mem[rd_ptr].
  - A word accepted at edge t is visible on out_data after edge t, when the FIFO was empty before the accept (1-cycle latency).
  - Pointers wrap modulo DEPTH.
  - Simultaneous accept and pop: level unchanged, both pointers advance.
  - Pop when empty and accept when full cannot occur by construction.
- Ordering: strict FIFO; no word dropped or duplicated.
- Signature, on each accept:
  - sig_next = rotl1(sig) ^ in_data, where rotl1 is a 1-bit left rotate over DATA_W bits.
  - frame_cnt increments.
  - When frame_cnt == FRAME_LEN-1 at accept time:
    - frame_sig <= sig_next.
    - sig <= 0 and frame_cnt <= 0.
    - frame_done = 1 for exactly the next cycle.
    - Back-to-back frames (FRAME_LEN=1) pulse frame_done on consecutive cycles.
- count: increments on accept and saturates at all-ones (no wrap). It is independent of frame boundaries and of FIFO pops.
- Signature and count are updated on accept regardless of downstream backpressure.
- Reset or clear mid-frame abandons the partial frame with no frame_done pulse.

Test Plan:
- Reset then idle: rst_n low 2 cycles → level=0, out_valid=0, in_ready=1, count=0, frame_sig=0, frame_done=0.
- Fill/drain, DEPTH=4, out_ready=0:
  - Push 0x011, 0x022, 0x033, 0x044 → level=4, in_ready=0.
  - 5th in_valid is not accepted.
  - Raise out_ready → out_data 0x011, 0x022, 0x033, 0x044 on successive cycles, then out_valid=0.
- Signature, FRAME_LEN=4: accept 0x3FF, 0x001, 0x200, 0x155 → frame_done pulses 1 cycle after the 4th accept, frame_sig=0x2AF, count=4.
- Simultaneous push/pop at level=2 with in_valid=out_ready=1 for 5 cycles → level stays 2, output order preserved, count advances by 5.
- clear asserted with an in_valid accept after 3 of 4 frame words → no frame_done, count=0, level=0. The next 4 words 0x3FF, 0x001, 0x200, 0x155 again give frame_sig=0x2AF.
- Saturation, CNT_W=4: 20 accepts → count holds 0xF, and signature and FIFO keep operating.
